// File: rtl/pipe_pkg.sv
// Shared constants and types for the reusable pipeline stage register.
// Control-bit indices follow the EX/MEM control field layout.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_REGWRITE = 3;

    // Field order matches the bit indices above (memread is the LSB).
    typedef struct packed {
        logic regwrite;
        logic memwrite;
        logic memtoreg;
        logic memread;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer: holds an entry accepted while the output register is stalled.
// Used by pipe_stage_reg only when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Clear wins over load so an entry accepted in a kill cycle is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (clr_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
            r_ctrl  <= ctrl_i;
        end else if (pop_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign ctrl_o  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with flush, start gate and saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and a registered in_ready_o.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // Handshake: an entry moves across a port on a rising edge where valid and
    // ready are both high; valid never depends on ready, ready may depend on valid.
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_src_valid;
    logic [DATA_W-1:0] w_src_data;
    logic [CTRL_W-1:0] w_src_ctrl;

    assign w_load   = !r_out_valid || out_ready_i;
    assign w_accept = in_valid_i && w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!start_i || flush_i),
        .load_i  (w_accept && !w_load),
        .pop_i   (w_load && w_skid_valid),
        .data_i  (in_data_i),
        .ctrl_i  (in_ctrl_i),
        .valid_o (w_skid_valid),
        .data_o  (w_skid_data),
        .ctrl_o  (w_skid_ctrl)
    );

    // Ready depends only on the skid flag, so out_ready_i never reaches in_ready_o.
    assign w_in_ready  = rst_i && start_i && !w_skid_valid;
    assign w_src_valid = w_skid_valid || w_accept;
    assign w_src_data  = w_skid_valid ? w_skid_data : in_data_i;
    assign w_src_ctrl  = w_skid_valid ? w_skid_ctrl : in_ctrl_i;
`else
    assign w_in_ready  = rst_i && start_i && w_load;
    assign w_src_valid = w_accept;
    assign w_src_data  = in_data_i;
    assign w_src_ctrl  = in_ctrl_i;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_bubble_cnt <= '0;
        end else if (!start_i) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (!r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (flush_i) begin
                r_out_valid <= 1'b0;
                r_out_ctrl  <= '0;
            end else if (w_load) begin
                // A bubble keeps the old data but must never leak control bits.
                if (w_src_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_src_data;
                    r_out_ctrl  <= w_src_ctrl;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= '0;
                end
            end
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = r_out_valid;
    assign out_data_o   = r_out_data;
    assign out_ctrl_o   = r_out_ctrl;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked by a
// transaction-level model (ordered queue of held entries, capacity rule, bubble count).
module tb_pipe_stage_reg;

    localparam int DATA_W    = 32;
    localparam int CTRL_W    = 4;
    localparam int CNT_W     = 3;
    localparam int EW        = DATA_W + CTRL_W;
    localparam int CNT_MAX_I = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAPACITY  = 2;
`else
    localparam int CAPACITY  = 1;
`endif

    logic              clk_i;
    logic              rst_i;
    logic              start_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_ctrl_i    (in_ctrl_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_ctrl_o   (out_ctrl_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0]     exp_q[$];
    int                cnt_m;
    logic [DATA_W-1:0] last_data;
    int                q_sz;
    logic              exp_rdy;
    logic [CTRL_W-1:0] exp_ctrl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model / monitor ----------------
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("rst_out_valid", 64'(out_valid_o), 64'd0);
            check("rst_out_data", 64'(out_data_o), 64'd0);
            check("rst_out_ctrl", 64'(out_ctrl_o), 64'd0);
            check("rst_bubble_cnt", 64'(bubble_cnt_o), 64'd0);
            check("rst_in_ready", 64'(in_ready_o), 64'd0);
            exp_q.delete();
            cnt_m     = 0;
            last_data = '0;
        end else begin
            q_sz = exp_q.size();
            if (q_sz != 0) begin
                last_data = exp_q[0][DATA_W-1:0];
                exp_ctrl  = exp_q[0][EW-1:DATA_W];
            end else begin
                exp_ctrl  = '0;
            end
`ifdef PIPE_STAGE_SKID_EN
            exp_rdy = start_i && (q_sz < CAPACITY);
`else
            exp_rdy = start_i && ((q_sz < CAPACITY) || out_ready_i);
`endif
            check("bubble_cnt", 64'(bubble_cnt_o), 64'(cnt_m));
            check("out_valid", 64'(out_valid_o), 64'(q_sz != 0));
            check("out_data", 64'(out_data_o), 64'(last_data));
            check("out_ctrl", 64'(out_ctrl_o), 64'(exp_ctrl));
            check("in_ready", 64'(in_ready_o), 64'(exp_rdy));

            if (q_sz != 0 && out_ready_i) void'(exp_q.pop_front());
            if (!start_i) begin
                exp_q.delete();
                cnt_m     = 0;
                last_data = '0;
            end else begin
                if (q_sz == 0 && cnt_m < CNT_MAX_I) cnt_m++;
                if (flush_i) exp_q.delete();
                else if (in_valid_i && exp_rdy) exp_q.push_back({in_ctrl_i, in_data_i});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        logic done;
        done       = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_ctrl_i  = c;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk_i);
            if (in_ready_o) done = 1'b1;
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        check("send_accepted", 64'(done), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] nd;
        int                stall_acc;

        rst_i       = 1'b0;
        start_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_ctrl_i   = '0;
        out_ready_i = 1'b1;
        repeat (2) tick();
        rst_i   = 1'b1;
        start_i = 1'b1;

        // Traffic, then reset asserted mid-stream and released with start low.
        for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 4'h5);
        in_valid_i = 1'b1;
        in_data_i  = 32'hA4;
        rst_i      = 1'b0;
        repeat (2) tick();
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        rst_i      = 1'b1;
        repeat (3) tick();
        check("start_low_ready", 64'(in_ready_o), 64'd0);
        check("start_low_cnt", 64'(bubble_cnt_o), 64'd0);
        start_i = 1'b1;
        repeat (5) tick();
        check("bubble_after_5", 64'(bubble_cnt_o), 64'd5);

        // Streaming with a 4-cycle stall while 0x12 is on the output.
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h10 + 32'(i), 4'hF);
        out_ready_i = 1'b0;
        nd          = 32'h13;
        stall_acc   = 0;
        in_valid_i  = 1'b1;
        in_data_i   = nd;
        in_ctrl_i   = 4'hF;
        repeat (4) begin
            logic acc;
            @(negedge clk_i);
            check("stall_hold_data", 64'(out_data_o), 64'h12);
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) begin
                stall_acc++;
                nd        = nd + 1;
                in_data_i = nd;
            end
        end
        in_valid_i = 1'b0;
        check("stall_accepts", 64'(stall_acc), 64'(CAPACITY - 1));
        out_ready_i = 1'b1;
        while (nd <= 32'h17) begin
            send(nd, 4'hF);
            nd = nd + 1;
        end
        repeat (3) tick();

        // Flush with the stage full and a valid entry offered in the flush cycle.
        out_ready_i = 1'b0;
        send(32'h30, 4'hA);
`ifdef PIPE_STAGE_SKID_EN
        send(32'h31, 4'hB);
`endif
        in_valid_i  = 1'b1;
        in_data_i   = 32'hEE;
        in_ctrl_i   = 4'hF;
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        check("flush_out_ctrl", 64'(out_ctrl_o), 64'd0);
        check("flush_ready", 64'(in_ready_o), 64'd1);
        repeat (3) tick();

        // Bubble between two entries with control bits still driven.
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        send(32'h40, 4'hF);
        in_ctrl_i = 4'hF;
        tick();
        check("bubble_ctrl", 64'(out_ctrl_o), 64'd0);
        check("bubble_cnt_before", 64'(bubble_cnt_o), 64'd1);
        send(32'h41, 4'hF);
        check("bubble_cnt_after", 64'(bubble_cnt_o), 64'd2);

        // Saturation.
        repeat (10) tick();
        check("bubble_saturated", 64'(bubble_cnt_o), 64'(CNT_MAX_I));

        // Random traffic.
        repeat (400) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            in_data_i   = $urandom;
            in_ctrl_i   = 4'($urandom_range(0, 15));
            flush_i     = ($urandom_range(0, 24) == 0);
            start_i     = ($urandom_range(0, 39) != 0);
            tick();
        end
        flush_i     = 1'b0;
        start_i     = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
